// File: rtl/timer_digit_entry.sv
// timer_digit_entry
//   Keypad digit-entry stage. Synchronizes the key encoder outputs, debounces
//   press and release, and accepts one digit per debounced press into a
//   4-digit MM:SS entry register. A start request commits a normalized copy
//   of the entry to the countdown timer with a one-cycle load pulse.
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   bcd[3:0]     digit code from the key encoder
//   valid_data   high while a key is held
//   start_n      active-low start request (level)
//   clear_n      active-low clear of the entry register (level)
//   disp_bcd     raw entry {min_tens, min_ones, sec_tens, sec_ones}
//   digit_count  accepted digits, 0..4
//   full         digit_count == 4
//   load_timer   one-cycle commit pulse
//   timer_bcd    normalized time while load_timer is high, else 0
module timer_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  bcd,
  input  logic        valid_data,
  input  logic        start_n,
  input  logic        clear_n,
  output logic [15:0] disp_bcd,
  output logic [2:0]  digit_count,
  output logic        full,
  output logic        load_timer,
  output logic [15:0] timer_bcd
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES);

  typedef struct packed {
    logic       v;
    logic [3:0] code;
    logic       start_n;
    logic       clear_n;
  } key_in_t;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} key_state_t;

  // ---------------------------------------------------------------------------
  // 2-flop synchronizers. sync_vld tracks pipeline fill after reset so the
  // key FSM can tell when v_s reflects the real input.
  // ---------------------------------------------------------------------------
  key_in_t    sync_q [2];
  logic [1:0] sync_vld;
  logic       v_s, start_s, clear_s;
  logic [3:0] bcd_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q[0] <= '0;
      sync_q[1] <= '0;
      sync_vld  <= '0;
    end else begin
      sync_q[0] <= '{v: valid_data, code: bcd, start_n: start_n, clear_n: clear_n};
      sync_q[1] <= sync_q[0];
      sync_vld  <= {sync_vld[0], 1'b1};
    end
  end

  assign v_s     = sync_q[1].v;
  assign bcd_s   = sync_q[1].code;
  assign start_s = sync_q[1].start_n;
  assign clear_s = sync_q[1].clear_n;

  // ---------------------------------------------------------------------------
  // Arming: a key held through reset must be released before it can be
  // accepted. armed sets once a genuine (post-fill) low is seen on v_s.
  // ---------------------------------------------------------------------------
  logic armed;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) armed <= 1'b0;
    else if (sync_vld[1] && !v_s) armed <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Key debounce FSM
  // ---------------------------------------------------------------------------
  key_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (armed && v_s) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = 8'd1;
        end
      end
      PRESS_DB: begin
        if (!v_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          accept    = 1'b1;
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HELD: begin
        if (!v_s) begin
          state_nxt = RELEASE_DB;
          cnt_nxt   = 8'd1;
        end
      end
      RELEASE_DB: begin
        if (v_s) begin
          // bounce during a hold: back to HELD without a new accept
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry register, start commit and clear
  // ---------------------------------------------------------------------------
  logic start_prev;
  logic start_fall;
  logic digit_ok;

  function automatic logic [15:0] normalize(input logic [15:0] t);
    // seconds tens above 5 saturate the seconds field to 59
    if (t[7:4] > 4'd5) return {t[15:8], 8'h59};
    return t;
  endfunction

  assign start_fall = start_prev && !start_s;
  assign digit_ok   = accept && (bcd_s <= 4'd9) && !full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_prev  <= 1'b1;
      disp_bcd    <= '0;
      digit_count <= '0;
      full        <= 1'b0;
      load_timer  <= 1'b0;
      timer_bcd   <= '0;
    end else begin
      start_prev <= start_s;
      load_timer <= 1'b0;
      timer_bcd  <= '0;
      if (!clear_s || load_timer) begin
        // explicit clear, or the edge after a commit
        disp_bcd    <= '0;
        digit_count <= '0;
        full        <= 1'b0;
      end else if (start_fall && digit_count != 3'd0) begin
        // commit the pre-shift value; a same-cycle accept is dropped
        load_timer <= 1'b1;
        timer_bcd  <= normalize(disp_bcd);
      end else if (digit_ok) begin
        disp_bcd    <= {disp_bcd[11:0], bcd_s};
        digit_count <= digit_count + 3'd1;
        full        <= (digit_count == 3'd3);
      end
    end
  end

endmodule

// File: tb/tb_timer_digit_entry.sv
module tb_timer_digit_entry;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  bcd;
  logic        valid_data;
  logic        start_n;
  logic        clear_n;
  logic [15:0] disp_bcd;
  logic [2:0]  digit_count;
  logic        full;
  logic        load_timer;
  logic [15:0] timer_bcd;

  int total = 0;
  int bad   = 0;

  // expected entry register contents
  logic [15:0] m_disp = '0;
  logic [2:0]  m_cnt  = '0;

  timer_digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bcd         (bcd),
    .valid_data  (valid_data),
    .start_n     (start_n),
    .clear_n     (clear_n),
    .disp_bcd    (disp_bcd),
    .digit_count (digit_count),
    .full        (full),
    .load_timer  (load_timer),
    .timer_bcd   (timer_bcd)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Press a key for 'hold' cycles then release for 'rel' cycles. The first
  // sampling edge is N; the register must be unchanged after N+5 and hold the
  // new value after N+6.
  task automatic press(input logic [3:0] d, input int hold, input int rel);
    logic [15:0] e_disp;
    logic [2:0]  e_cnt;
    e_disp = m_disp;
    e_cnt  = m_cnt;
    if (d <= 4'd9 && m_cnt < 3'd4) begin
      e_disp = {m_disp[11:0], d};
      e_cnt  = m_cnt + 3'd1;
    end
    bcd = d;
    valid_data = 1'b1;
    tick(6);
    chk("press_pre_disp", 32'(disp_bcd), 32'(m_disp));
    tick(1);
    chk("press_post_disp", 32'(disp_bcd), 32'(e_disp));
    chk("press_post_cnt", 32'(digit_count), 32'(e_cnt));
    m_disp = e_disp;
    m_cnt  = e_cnt;
    tick(hold - 7);
    valid_data = 1'b0;
    tick(rel);
  endtask

  initial begin
    resetn = 1'b0; bcd = '0; valid_data = 1'b0; start_n = 1'b1; clear_n = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(5);
    chk("rst_disp", 32'(disp_bcd), 32'h0);
    chk("rst_cnt", 32'(digit_count), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_load", 32'(load_timer), 32'h0);
    chk("rst_timer", 32'(timer_bcd), 32'h0);

    // reset mid-press, key kept held through and after reset
    bcd = 4'd5; valid_data = 1'b1;
    tick(3);
    resetn = 1'b0;
    tick(1);
    chk("inrst_disp", 32'(disp_bcd), 32'h0);
    chk("inrst_cnt", 32'(digit_count), 32'h0);
    resetn = 1'b1;
    tick(15);
    chk("held_thru_rst_cnt", 32'(digit_count), 32'h0);
    chk("held_thru_rst_disp", 32'(disp_bcd), 32'h0);
    valid_data = 1'b0;
    tick(10);

    // digit entry 1,2,3,0
    press(4'd1, 10, 10);
    press(4'd2, 10, 10);
    press(4'd3, 10, 10);
    press(4'd0, 10, 10);
    chk("entry_disp", 32'(disp_bcd), 32'h1230);
    chk("entry_cnt", 32'(digit_count), 32'd4);
    chk("entry_full", 32'(full), 32'd1);

    // fifth press on full register
    press(4'd7, 10, 10);
    chk("ovf_disp", 32'(disp_bcd), 32'h1230);

    // clear latency: still set after C+1, zero after C+2
    clear_n = 1'b0;
    tick(2);
    chk("clr_c1_disp", 32'(disp_bcd), 32'h1230);
    tick(1);
    chk("clr_c2_disp", 32'(disp_bcd), 32'h0);
    chk("clr_c2_full", 32'(full), 32'h0);
    clear_n = 1'b1;
    m_disp = '0; m_cnt = '0;
    tick(4);

    // 3-cycle glitch
    bcd = 4'd8; valid_data = 1'b1;
    tick(3);
    valid_data = 1'b0;
    tick(12);
    chk("glitch_disp", 32'(disp_bcd), 32'h0);
    chk("glitch_cnt", 32'(digit_count), 32'h0);

    // 2-cycle low bounce during a hold
    bcd = 4'd4; valid_data = 1'b1;
    tick(10);
    valid_data = 1'b0;
    tick(2);
    valid_data = 1'b1;
    tick(8);
    valid_data = 1'b0;
    tick(10);
    chk("bounce_disp", 32'(disp_bcd), 32'h0004);
    chk("bounce_cnt", 32'(digit_count), 32'd1);

    clear_n = 1'b0;
    tick(4);
    clear_n = 1'b1;
    tick(3);
    chk("clr2_disp", 32'(disp_bcd), 32'h0);
    m_disp = '0; m_cnt = '0;

    // start with normalization
    press(4'd0, 10, 10);
    press(4'd1, 10, 10);
    press(4'd7, 10, 10);
    press(4'd5, 10, 10);
    chk("pre_start_disp", 32'(disp_bcd), 32'h0175);
    start_n = 1'b0;
    tick(2);
    chk("start_m1_load", 32'(load_timer), 32'h0);
    chk("start_m1_timer", 32'(timer_bcd), 32'h0);
    tick(1);
    chk("start_m2_load", 32'(load_timer), 32'h1);
    chk("start_m2_timer", 32'(timer_bcd), 32'h0159);
    chk("start_m2_disp", 32'(disp_bcd), 32'h0175);
    tick(1);
    chk("start_m3_load", 32'(load_timer), 32'h0);
    chk("start_m3_timer", 32'(timer_bcd), 32'h0);
    chk("start_m3_disp", 32'(disp_bcd), 32'h0);
    chk("start_m3_cnt", 32'(digit_count), 32'h0);
    m_disp = '0; m_cnt = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("start_hold_load", 32'(load_timer), 32'h0);
    end
    start_n = 1'b1;
    tick(5);

    // start on empty register
    start_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("start_empty_load", 32'(load_timer), 32'h0);
    end
    start_n = 1'b1;
    tick(5);

    // start and accept land on the same edge (N+6 == M+2)
    press(4'd1, 10, 10);
    press(4'd2, 10, 10);
    bcd = 4'd3; valid_data = 1'b1;
    tick(4);
    start_n = 1'b0;
    tick(3);
    chk("prio_sa_load", 32'(load_timer), 32'h1);
    chk("prio_sa_timer", 32'(timer_bcd), 32'h0012);
    chk("prio_sa_disp", 32'(disp_bcd), 32'h0012);
    tick(1);
    chk("prio_sa_clr_disp", 32'(disp_bcd), 32'h0);
    chk("prio_sa_clr_cnt", 32'(digit_count), 32'h0);
    tick(5);
    valid_data = 1'b0;
    start_n = 1'b1;
    tick(10);
    chk("prio_sa_after_cnt", 32'(digit_count), 32'h0);
    m_disp = '0; m_cnt = '0;

    // clear and start together
    press(4'd9, 10, 10);
    chk("pre_cs_disp", 32'(disp_bcd), 32'h0009);
    clear_n = 1'b0; start_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("prio_cs_load", 32'(load_timer), 32'h0);
    end
    chk("prio_cs_disp", 32'(disp_bcd), 32'h0);
    chk("prio_cs_cnt", 32'(digit_count), 32'h0);
    clear_n = 1'b1; start_n = 1'b1;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_digit_entry.md
# timer_digit_entry

Keypad digit-entry stage for the timer-entry/control path. Consumes the key encoder's `bcd`/`valid_data` pair and performs synchronization, press/release debouncing and single-digit acceptance per keypress. Accepted digits shift into a 4-digit MM:SS register shown on the display. On a start request, the block hands a normalized BCD time to the countdown timer with a one-cycle load pulse.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronized cycles a level must hold before a press or release is accepted (range 1–255).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `bcd`  in  4  digit code from the key encoder.
- `valid_data`  in  1  high while a key is held.
- `start_n`  in  1  active-low start request, level.
- `clear_n`  in  1  active-low clear of the entry register, level.
- `disp_bcd`  out  16  raw entry {min_tens, min_ones, sec_tens, sec_ones}.
- `digit_count`  out  3  number of accepted digits, 0–4.
- `full`  out  1  high when `digit_count` == 4.
- `load_timer`  out  1  one-cycle pulse that commits the time to the timer.
- `timer_bcd`  out  16  normalized time; valid only while `load_timer` is 1, otherwise 16'h0000.

## Operation
- **Synchronization.** `valid_data`, `bcd`, `start_n` and `clear_n` each pass through a 2-flop synchronizer. All logic below uses the synchronized copies (`v_s`, `bcd_s`, `start_s`, `clear_s`).
- **Key FSM states:** IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: if `v_s`=1, go to PRESS_DB and set the counter to 1.
  - PRESS_DB: if `v_s`=0, return to IDLE. Otherwise increment the counter.
  - PRESS_DB, counter reaches `DEBOUNCE_CYCLES` with `v_s`=1: generate an accept strobe, capture `bcd_s`, go to HELD.
  - HELD: if `v_s`=0, go to RELEASE_DB and set the counter to 1.
  - RELEASE_DB: if `v_s`=1, return to HELD. Otherwise the counter counts.
  - RELEASE_DB, counter reaches `DEBOUNCE_CYCLES`: go to IDLE.
  - Result: exactly one accept per debounced press. Bounce within a hold never re-accepts.
- **Accepting a digit.**
  - If `bcd_s` > 9, the digit is discarded and no register changes.
  - Else if `full`=1, the digit is discarded.
  - Else the register shifts left one digit: {d2,d1,d0,new}, and `digit_count` increments.
- **Clear.** `clear_s`=0 zeroes `disp_bcd` and `digit_count` at the next edge. The FSM is unaffected.
- **Start.**
  - A falling edge on `start_s` with `digit_count` > 0 raises `load_timer` for exactly one cycle. At the following edge, `disp_bcd` and `digit_count` clear.
  - A falling edge with `digit_count` = 0 produces no pulse.
  - Holding `start_s` low produces no further pulses.
- **Normalization (`timer_bcd`).**
  - min_tens and min_ones pass through unchanged.
  - If sec_tens > 5, the seconds field becomes 5,9. Otherwise the seconds pass through.
- **Simultaneous events.** Priority is clear > start > accept.
  - Start and accept in the same cycle: the pre-shift value is committed and the digit is discarded.
  - Clear and start in the same cycle: no pulse, register cleared.
- **Reset.** Asserting `resetn` (low) puts the FSM in IDLE and zeroes the counter, synchronizers, `disp_bcd`, `digit_count`, `full`, `load_timer` and `timer_bcd`.
  - The start edge detector's previous value resets to 1, so `start_n` held low through reset does not pulse.
  - A press in progress at reset is lost; the key must be released and pressed again.

## Timing
- **Digit latency.** Let edge N be the first edge sampling `valid_data`=1, held high continuously. `disp_bcd` and `digit_count` update at edge N+2+`DEBOUNCE_CYCLES`: edge N+6 for the default.
- **Release-to-rearm.** With `valid_data` low from edge R, the FSM reaches IDLE at edge R+2+`DEBOUNCE_CYCLES`.
  - The next press is accepted if `valid_data` is still high when the FSM returns to IDLE.
- **Press abort.** A press that drops before its accept edge produces no change.
- **Start latency.** Let edge M be the first edge sampling `start_n`=0.
  - `load_timer`=1 during the cycle after edge M+2.
  - The register clears at edge M+3.
- **Clear latency.** Clear takes effect at edge C+2, where C is the first edge sampling `clear_n`=0.
- `full` and `digit_count` are registered and consistent with `disp_bcd` on every cycle.

## Test plan
- **Reset values.** Assert `resetn`=0 mid-press, then release reset → all outputs 0 and FSM in IDLE. Holding the key through reset causes no accept until it is released and pressed again.
- **Digit entry.** Press 1, 2, 3, 0, each held 10 cycles with 10 cycles released.
  - `disp_bcd` = 16'h1230 and `digit_count` = 4, `full` = 1.
  - Each update lands at edge N+6.
- **Overflow and bounce.**
  - A fifth press of 7 on a full register → `disp_bcd` unchanged.
  - A 3-cycle glitch on `valid_data` → no accept.
  - A 2-cycle low bounce during a hold → no second accept.
- **Start with normalization.** Entry 0,1,7,5 then `start_n` low.
  - `load_timer` is high for 1 cycle with `timer_bcd` = 16'h0159.
  - Next cycle: `disp_bcd` = 0, `digit_count` = 0.
- **Start on empty register.** `start_n` pulse with `digit_count` = 0 → no `load_timer`.
- **Priority.** Start and accept in the same cycle on 12 → commits 16'h0012 and the digit is dropped. Start and clear together → no pulse, register 0.
